// File: rtl/mul_div_unit.sv
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative RV32M multiply/divide unit (32 shift-add or
//               restoring shift-subtract steps, then one sign-fix cycle).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] Result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_opnd;
    logic [4:0]  r_cnt;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_div_zero;
    logic        w_overflow;
    logic        w_special;
    logic [31:0] w_special_res;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_fix_res;

    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_a_neg    = w_a_signed && A[31];
    assign w_b_neg    = w_b_signed && B[31];
    assign w_a_mag    = w_a_neg ? (~A + 32'd1) : A;
    assign w_b_mag    = w_b_neg ? (~B + 32'd1) : B;

    assign w_div_zero = funct3[2] && (B == 32'd0);
    assign w_overflow = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                        (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign w_special  = w_div_zero || w_overflow;

    always_comb begin
        w_special_res = 32'd0;
        if (w_div_zero)
            w_special_res = funct3[1] ? A : 32'hFFFF_FFFF;
        else
            w_special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // Multiply keeps the multiplier in r_lo and shifts the product in from the top;
    // divide shifts the dividend out of r_lo into the partial remainder r_hi.
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_div_shift = {r_hi, r_lo[31]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};

    assign w_prod_fix = r_neg_q ? (~{r_hi, r_lo} + 64'd1) : {r_hi, r_lo};
    assign w_quot_fix = r_neg_q ? (~r_lo + 32'd1) : r_lo;
    assign w_rem_fix  = r_neg_r ? (~r_hi + 32'd1) : r_hi;

    always_comb begin
        w_fix_res = 32'd0;
        case (r_op)
            3'b000:                 w_fix_res = w_prod_fix[31:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[63:32];
            3'b100, 3'b101:         w_fix_res = w_quot_fix;
            default:                w_fix_res = w_rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_next = S_IDLE;
                if (w_accept)
                    w_next = w_special ? S_DONE : S_RUN;
            end
            S_RUN:   if (r_cnt == 5'd31) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= 3'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_opnd   <= 32'd0;
            r_cnt    <= 5'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_op    <= funct3;
                        r_hi    <= 32'd0;
                        r_lo    <= w_a_mag;
                        r_opnd  <= w_b_mag;
                        r_cnt   <= 5'd0;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        if (w_special)
                            r_result <= w_special_res;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_op[2]) begin
                        if (!w_div_diff[32]) begin
                            r_hi <= w_div_diff[31:0];
                            r_lo <= {r_lo[30:0], 1'b1};
                        end else begin
                            r_hi <= w_div_shift[31:0];
                            r_lo <= {r_lo[30:0], 1'b0};
                        end
                    end else begin
                        {r_hi, r_lo} <= {w_mul_sum, r_lo[31:1]};
                    end
                end
                S_FIX:   r_result <= w_fix_res;
                default: ;
            endcase
        end
    end

    assign busy   = (r_state == S_RUN) || (r_state == S_FIX);
    assign done   = (r_state == S_DONE);
    assign Result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Table-driven, scoreboard-checked bench for mul_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] Result;

    mul_div_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .Result (Result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        int          lat;
        int          acc;
    } sb_t;

    sb_t  q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Independent reference built on the simulator's own signed/unsigned arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] a32, b32, r32;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        a32 = a;
        b32 = b;
        p = 64'sd0;
        r32 = 32'sd0;
        case (f)
            3'd0: begin p = ua * ub; r32 = p[31:0]; end
            3'd1: begin p = sa * sb; r32 = p[63:32]; end
            3'd2: begin p = sa * ub; r32 = p[63:32]; end
            3'd3: begin p = ua * ub; r32 = p[63:32]; end
            3'd4: r32 = (b == 0) ? -32'sd1 : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a32 : a32 / b32);
            3'd5: r32 = (b == 0) ? -32'sd1 : a / b;
            3'd6: r32 = (b == 0) ? a32 : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'sd0 : a32 % b32);
            default: r32 = (b == 0) ? a32 : a % b;
        endcase
        return r32;
    endfunction

    function automatic int lat_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0)) return 1;
        if (!f[0] && f[2] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Scoreboard: pops one entry per done pulse; checks busy on every other cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    sb_t e;
                    e = q.pop_front();
                    check("result", Result, e.exp);
                    check("latency", cyc - e.acc, e.lat);
                    check("busy_at_done", {31'd0, busy}, 32'd0);
                end
            end else if (q.size() > 0 && q[0].acc < cyc) begin
                check("busy_in_flight", {31'd0, busy},
                      {31'd0, (q[0].lat == 34) && (cyc - q[0].acc <= 33)});
            end else if (q.size() == 0) begin
                check("busy_idle", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Called at posedge+2; leaves the bench one cycle later with operands scrambled.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        sb_t e;
        funct3 = f;
        A      = a;
        B      = b;
        start  = 1'b1;
        e.exp  = exp;
        e.lat  = lat;
        e.acc  = cyc;
        q.push_back(e);
        @(posedge clk); #2;
        start  = 1'b0;
        funct3 = 3'($urandom);
        A      = $urandom;
        B      = $urandom;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 80 && q.size() > 0; i++) begin
            @(posedge clk); #2;
        end
        if (q.size() > 0) begin
            check("timeout_waiting_done", 32'd1, 32'd0);
            q.delete();
        end
    endtask

    vec_t tbl[18];

    initial begin
        tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
        tbl[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
        tbl[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
        tbl[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
        tbl[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
        tbl[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        tbl[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
        tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        tbl[12] = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        tbl[13] = '{3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1};
        tbl[14] = '{3'd1, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34};
        tbl[15] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
        tbl[16] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         34};
        tbl[17] = '{3'd4, 32'h8000_0000,  32'd2,         32'hC000_0000, 34};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", Result, 32'd0);
        @(posedge clk); #2;
        rst    = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < 18; i++) begin
            issue(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);
            wait_empty();
        end

        for (int i = 0; i < 10; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            issue(f, a, b, model(f, a, b), lat_model(f, a, b));
            wait_empty();
        end

        // A second start mid-run must be ignored; then a start in the DONE cycle is taken.
        issue(3'd5, 32'd100, 32'd7, 32'd14, 34);
        repeat (9) begin @(posedge clk); #2; end
        start = 1'b1; funct3 = 3'd0; A = 32'd3; B = 32'd5;
        @(posedge clk); #2;
        start = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #2;
        end
        check("b2b_done_seen", {31'd0, done}, 32'd1);
        issue(3'd0, 32'd6, 32'd7, 32'd42, 34);
        wait_empty();

        // Reset mid-run aborts without a done pulse.
        issue(3'd0, 32'd9, 32'd9, 32'd81, 34);
        repeat (9) begin @(posedge clk); #2; end
        chk_en = 1'b0;
        rst    = 1'b1;
        q.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", Result, 32'd0);
        chk_en = 1'b1;
        repeat (30) begin @(posedge clk); #2; end
        issue(3'd3, 32'hFFFF_FFFF, 32'd2, 32'd1, 34);
        wait_empty();

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
